// File: rtl/bpm_scaler_div.sv
// Tempo-to-scaler converter: scaler = round(NUMERATOR / bpm) using a bit-serial
// restoring divider with a start/busy/done handshake and a held, registered result.
module bpm_scaler_div #(
   parameter int          IN_W      = 8,
   parameter int          OUT_W     = 20,
   parameter int unsigned NUMERATOR = 1000000,
   parameter int          NUM_W     = 21
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IN_W-1:0]  bpm,
   output logic             busy,
   output logic             done,
   output logic [OUT_W-1:0] scaler,
   output logic             err
);

   localparam int CNT_W = (NUM_W > 2) ? $clog2(NUM_W) : 1;
   localparam int EXT_W = NUM_W + OUT_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t state_r, state_s;

   logic [IN_W-1:0]  div_r;
   logic [NUM_W-1:0] dvd_r;   // dividend bits leave at the MSB, quotient bits enter at the LSB
   logic [IN_W:0]    rem_r;
   logic [CNT_W-1:0] cnt_r;
   logic             busy_r;
   logic             done_r;
   logic             err_r;
   logic [OUT_W-1:0] scaler_r;

   logic [IN_W:0]    rem_shift_s;
   logic [IN_W:0]    rem_next_s;
   logic             q_bit_s;
   logic [EXT_W-1:0] quot_ext_s;
   logic             sat_s;

   // One restoring step plus the saturation / divide-by-zero decision.
   always_comb begin
      rem_shift_s = (rem_r << 1'b1) | (IN_W+1)'(dvd_r[NUM_W-1]);
      rem_next_s  = rem_shift_s;
      q_bit_s     = 1'b0;
      if (rem_shift_s >= {1'b0, div_r}) begin
         rem_next_s = rem_shift_s - {1'b0, div_r};
         q_bit_s    = 1'b1;
      end else begin
         rem_next_s = rem_shift_s;
         q_bit_s    = 1'b0;
      end
      quot_ext_s = EXT_W'(dvd_r);
      sat_s      = (div_r == {IN_W{1'b0}}) || (quot_ext_s > EXT_W'({OUT_W{1'b1}}));
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = DIV;
            end else begin
               state_s = IDLE;
            end
         end
         DIV: begin
            if (cnt_r == {CNT_W{1'b0}}) begin
               state_s = FIN;
            end else begin
               state_s = DIV;
            end
         end
         FIN:     state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Divider datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_r    <= {IN_W{1'b0}};
         dvd_r    <= {NUM_W{1'b0}};
         rem_r    <= {(IN_W+1){1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
         scaler_r <= {OUT_W{1'b1}};
      end else begin
         done_r <= 1'b0;
         busy_r <= (state_s != IDLE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  div_r <= bpm;
                  dvd_r <= NUM_W'(NUMERATOR) + NUM_W'(bpm >> 1'b1);
                  rem_r <= {(IN_W+1){1'b0}};
                  cnt_r <= CNT_W'(NUM_W - 1);
               end
            end
            DIV: begin
               dvd_r <= {dvd_r[NUM_W-2:0], q_bit_s};
               rem_r <= rem_next_s;
               if (cnt_r != {CNT_W{1'b0}}) begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end
            end
            FIN: begin
               done_r   <= 1'b1;
               err_r    <= sat_s;
               scaler_r <= sat_s ? {OUT_W{1'b1}} : quot_ext_s[OUT_W-1:0];
            end
            default: begin
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_r;
   assign done   = done_r;
   assign scaler = scaler_r;
   assign err    = err_r;

endmodule

// File: tb/tb_bpm_scaler_div.sv
// Self-checking bench for bpm_scaler_div: directed handshake scenarios plus an
// exhaustive/random bpm sweep against an arithmetic round-half-up reference.
module tb_bpm_scaler_div;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_a = 1'b0;
   logic        start_b = 1'b0;
   logic [7:0]  bpm = 8'd0;
   logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
   logic [19:0] scaler_a, scaler_b;

   int total = 0;
   int bad = 0;
   int dcnt_a = 0;
   int dcnt_b = 0;

   bpm_scaler_div dut_a (
      .clk(clk), .rst(rst), .start(start_a), .bpm(bpm),
      .busy(busy_a), .done(done_a), .scaler(scaler_a), .err(err_a)
   );

   bpm_scaler_div #(.NUMERATOR(60000000), .NUM_W(27)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .bpm(bpm),
      .busy(busy_b), .done(done_b), .scaler(scaler_b), .err(err_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done_a === 1'b1) dcnt_a <= dcnt_a + 1;
      if (done_b === 1'b1) dcnt_b <= dcnt_b + 1;
   end

   // Reference: {err, scaler} = round-half-up(num / b), saturating to 20 bits.
   function automatic logic [20:0] model(input longint num, input int b);
      longint q;
      if (b == 0) return {1'b1, 20'hFFFFF};
      q = (2 * num + b) / (2 * b);
      if (q > 64'd1048575) return {1'b1, 20'hFFFFF};
      return {1'b0, q[19:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Accept one conversion, measure latency and busy length, capture the result.
   task automatic conv(input bit sel_b, input logic [7:0] b, output int lat, output int bcyc,
                       output logic [19:0] sc, output logic er);
      @(negedge clk);
      bpm = b;
      if (sel_b) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
      lat = 0;
      bcyc = 0;
      while (((sel_b ? done_b : done_a) !== 1'b1) && lat < 200) begin
         if ((sel_b ? busy_b : busy_a) === 1'b1) bcyc++;
         @(posedge clk); #1;
         lat++;
      end
      sc = sel_b ? scaler_b : scaler_a;
      er = sel_b ? err_b : err_a;
      @(posedge clk); #1;
      chk("done_one_cycle", {63'd0, (sel_b ? done_b : done_a)}, 64'd0);
   endtask

   task automatic run(input bit sel_b, input logic [7:0] b, output logic [19:0] sc, output logic er);
      int lat, bcyc, d0, nw;
      logic [20:0] exp;
      longint num;
      num = sel_b ? 64'd60000000 : 64'd1000000;
      nw  = sel_b ? 27 : 21;
      d0  = sel_b ? dcnt_b : dcnt_a;
      conv(sel_b, b, lat, bcyc, sc, er);
      exp = model(num, int'(b));
      chk("scaler", {44'd0, sc}, {44'd0, exp[19:0]});
      chk("err", {63'd0, er}, {63'd0, exp[20]});
      chk("latency", 64'(lat), 64'(nw + 1));
      chk("busy_cycles", 64'(bcyc), 64'(nw + 1));
      chk("done_count", 64'((sel_b ? dcnt_b : dcnt_a) - d0), 64'd1);
   endtask

   initial begin
      logic [19:0] sc;
      logic        er;
      logic [20:0] exp;
      int          lat, d0;
      logic [7:0]  dir [0:6];

      dir[0] = 8'd6;  dir[1] = 8'd128; dir[2] = 8'd3; dir[3] = 8'd1;
      dir[4] = 8'd255; dir[5] = 8'd0;  dir[6] = 8'd60;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {63'd0, busy_a}, 64'd0);
      chk("rst_done", {63'd0, done_a}, 64'd0);
      chk("rst_err", {63'd0, err_a}, 64'd0);
      chk("rst_scaler", {44'd0, scaler_a}, 64'hFFFFF);
      chk("rst_scaler_b", {44'd0, scaler_b}, 64'hFFFFF);
      @(negedge clk);
      rst = 1'b0;

      run(1'b0, 8'd120, sc, er);
      chk("bpm120_const", {44'd0, sc}, 64'd8333);

      for (int i = 0; i < 7; i++) begin
         run(1'b0, dir[i], sc, er);
      end
      run(1'b0, 8'd128, sc, er);
      chk("bpm128_const", {44'd0, sc}, 64'd7813);
      run(1'b0, 8'd0, sc, er);
      chk("bpm0_const", {44'd0, sc}, 64'hFFFFF);
      chk("bpm0_err", {63'd0, er}, 64'd1);

      for (int b = 1; b < 256; b++) begin
         run(1'b0, 8'(b), sc, er);
      end
      for (int i = 0; i < 20; i++) begin
         run(1'b0, 8'($urandom_range(0, 255)), sc, er);
      end

      // Start while busy is ignored; bpm change after acceptance has no effect
      @(negedge clk);
      bpm = 8'd50;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      d0 = dcnt_a;
      lat = 0;
      repeat (4) begin
         @(posedge clk); #1;
         lat++;
      end
      @(negedge clk);
      bpm = 8'd200;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      lat++;
      while (done_a !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      exp = model(64'd1000000, 50);
      chk("ignore_latency", 64'(lat), 64'd22);
      chk("ignore_scaler", {44'd0, scaler_a}, {44'd0, exp[19:0]});
      @(posedge clk); #1;
      chk("ignore_done_count", 64'(dcnt_a - d0), 64'd1);
      chk("ignore_idle", {63'd0, busy_a}, 64'd0);

      // Start raised during the FIN cycle is ignored
      @(negedge clk);
      bpm = 8'd7;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (21) @(posedge clk);
      @(negedge clk);
      bpm = 8'd9;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      exp = model(64'd1000000, 7);
      chk("fin_done", {63'd0, done_a}, 64'd1);
      chk("fin_scaler", {44'd0, scaler_a}, {44'd0, exp[19:0]});
      chk("fin_start_ignored", {63'd0, busy_a}, 64'd0);
      @(posedge clk); #1;
      chk("fin_still_idle", {63'd0, busy_a}, 64'd0);

      // Reset mid-conversion aborts without a done pulse
      @(negedge clk);
      bpm = 8'd77;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", {63'd0, busy_a}, 64'd0);
      chk("abort_done", {63'd0, done_a}, 64'd0);
      chk("abort_scaler", {44'd0, scaler_a}, 64'hFFFFF);
      chk("abort_err", {63'd0, err_a}, 64'd0);
      d0 = dcnt_a;
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("abort_no_done", 64'(dcnt_a - d0), 64'd0);
      chk("abort_idle", {63'd0, busy_a}, 64'd0);
      run(1'b0, 8'd100, sc, er);
      chk("bpm100_const", {44'd0, sc}, 64'd10000);

      // Larger numerator instance: saturation and 28-edge latency
      run(1'b1, 8'd1, sc, er);
      chk("b_sat_scaler", {44'd0, sc}, 64'hFFFFF);
      chk("b_sat_err", {63'd0, er}, 64'd1);
      run(1'b1, 8'd100, sc, er);
      chk("b_bpm100_const", {44'd0, sc}, 64'd600000);
      for (int i = 0; i < 8; i++) begin
         run(1'b1, 8'($urandom_range(0, 255)), sc, er);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
